seq_shifter: RTL and testbench

//   Parametrised, multi-cycle shift unit. Generalises the fixed 3-position SRA/SLL circuit.
//   - Runtime shift amount and mode (SLL/SRL/SRA, optional ROR).
//   - Shifts up to STEP positions per clock, trading latency for area.
//   - Valid/ready handshake on both sides; sits between the operand register stage
//     and the writeback stage of the datapath.
//

---
 rtl/seq_shifter.sv | 178 +++++++++++++++++
 tb/tb_seq_shifter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/seq_shifter.sv
//==============================================================================
// Module      : seq_shifter
// Description : Multi-cycle shift unit with valid/ready handshakes on both
//               sides. Supports SLL, SRL and SRA with a runtime shift amount,
//               moving up to STEP positions per clock. Mode 11 is a rotate
//               right when SEQ_SHIFT_ROTATE_EN is defined, otherwise it is a
//               single-cycle pass-through and no rotate logic is built.
// Config      : SEQ_SHIFT_ROTATE_EN (optional macro, enables ROR on mode 11)
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module seq_shifter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  // Operation encodings on in_mode.
  localparam logic [1:0] C_MODE_SLL = 2'b00;
  localparam logic [1:0] C_MODE_SRL = 2'b01;
  localparam logic [1:0] C_MODE_SRA = 2'b10;
  localparam logic [1:0] C_MODE_ROR = 2'b11;

  // One extra bit so that STEP == WIDTH (a power of two) still fits.
  localparam logic [SHW:0] C_STEP  = (SHW+1)'(STEP);
`ifdef SEQ_SHIFT_ROTATE_EN
  localparam logic [SHW:0] C_WIDTH = (SHW+1)'(WIDTH);
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [WIDTH-1:0] r_work;      // operand being shifted step by step
  logic [SHW-1:0]   r_rem;       // positions still to shift
  logic [1:0]       r_mode;      // latched operation
  logic             r_sign;      // original MSB, used as SRA fill
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;

  logic             w_accept;
  logic             w_pass;      // request completes without any shift step
  logic [SHW-1:0]   w_step_n;    // positions shifted this cycle
  logic [SHW-1:0]   w_rem_after;
  logic [WIDTH-1:0] w_fill_mask; // top w_step_n bits set
  logic [WIDTH-1:0] w_shifted;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  assign w_accept = in_valid && (r_state == S_IDLE);

  // A zero shift amount finishes immediately; without rotate support mode 11
  // is a pure pass-through and also skips the shift phase.
`ifdef SEQ_SHIFT_ROTATE_EN
  assign w_pass = (in_shamt == '0);
`else
  assign w_pass = (in_shamt == '0) || (in_mode == C_MODE_ROR);
`endif

  // Step size: min(STEP, remaining). rem is always below WIDTH, so the
  // truncated C_STEP is only selected when it is a valid SHW-bit value.
  assign w_step_n    = ({1'b0, r_rem} < C_STEP) ? r_rem : C_STEP[SHW-1:0];
  assign w_rem_after = r_rem - w_step_n;
  assign w_fill_mask = ~({WIDTH{1'b1}} >> w_step_n);

  // One shift step of the working register according to the latched mode.
  always_comb begin
    w_shifted = r_work;
    case (r_mode)
      C_MODE_SLL: w_shifted = r_work << w_step_n;
      C_MODE_SRL: w_shifted = r_work >> w_step_n;
      C_MODE_SRA: w_shifted = (r_work >> w_step_n) | (r_sign ? w_fill_mask : '0);
`ifdef SEQ_SHIFT_ROTATE_EN
      // w_step_n is never zero in BUSY, so the left shift is below WIDTH.
      C_MODE_ROR: w_shifted = (r_work >> w_step_n) |
                              (r_work << (C_WIDTH - {1'b0, w_step_n}));
`endif
      default:    w_shifted = r_work;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next_state = w_pass ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        if (w_rem_after == '0) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Datapath: latch on accept, shift while busy, hold result until taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_work      <= '0;
      r_rem       <= '0;
      r_mode      <= C_MODE_SLL;
      r_sign      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_work <= in_data;
            r_rem  <= w_pass ? '0 : in_shamt;
            r_mode <= in_mode;
            r_sign <= (in_mode == C_MODE_SRA) ? in_data[WIDTH-1] : 1'b0;
            if (w_pass) begin
              r_out_valid <= 1'b1;
              r_out_data  <= in_data;
            end
          end
        end
        S_BUSY: begin
          r_work <= w_shifted;
          r_rem  <= w_rem_after;
          if (w_rem_after == '0) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_shifted;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_shifter.sv
//==============================================================================
// Module      : tb_seq_shifter
// Description : Self-checking bench for seq_shifter (WIDTH=32, STEP=4).
//               Expected result and latency are queued when a request is
//               driven and compared when the DUT presents its result.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_seq_shifter;

  localparam int WIDTH = 32;
  localparam int STEP  = 4;
  localparam int SHW   = 5;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic [SHW-1:0]   in_shamt = '0;
  logic [1:0]       in_mode = 2'b00;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               lat;
  } exp_t;

  exp_t q_exp[$];
  int   n_cmp = 0;
  int   n_err = 0;

  seq_shifter #(.WIDTH(WIDTH), .STEP(STEP)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] model_data(input logic [WIDTH-1:0] d,
                                                   input int sh, input logic [1:0] m);
    case (m)
      2'b00: return d << sh;
      2'b01: return d >> sh;
      2'b10: return WIDTH'($signed(d) >>> sh);
      default: begin
`ifdef SEQ_SHIFT_ROTATE_EN
        if (sh == 0) return d;
        return (d >> sh) | (d << (WIDTH - sh));
`else
        return d;
`endif
      end
    endcase
  endfunction

  function automatic int model_lat(input int sh, input logic [1:0] m);
`ifndef SEQ_SHIFT_ROTATE_EN
    if (m == 2'b11) return 1;
`endif
    return 1 + (sh + STEP - 1) / STEP;
  endfunction

  // Runs one request starting and ending at a falling edge. stall = cycles
  // the result is held back; pend = raise in_valid for a follow-up request
  // during the stall.
  task automatic run_req(input logic [WIDTH-1:0] d, input int sh, input logic [1:0] m,
                         input int stall, input bit pend);
    exp_t             e;
    int               lat;
    logic [WIDTH-1:0] held;
    check_value("in_ready_before_req", in_ready, 1);
    in_data  = d;
    in_shamt = SHW'(sh);
    in_mode  = m;
    in_valid = 1'b1;
    e.data = model_data(d, sh, m);
    e.lat  = model_lat(sh, m);
    q_exp.push_back(e);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom;
    in_shamt = SHW'($urandom_range(31));
    in_mode  = 2'($urandom_range(3));
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) check_value("out_valid_timeout", out_valid, 1);
    held = out_data;
    for (int i = 0; i < stall; i++) begin
      if (pend && i == 0) begin
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
      end
      @(negedge clk);
      check_value("stall_out_valid", out_valid, 1);
      check_value("stall_out_data", out_data, held);
      check_value("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    e = q_exp.pop_front();
    check_value("result_data", out_data, e.data);
    check_value("result_latency", lat, e.lat);
    @(negedge clk);
    out_ready = 1'b0;
    check_value("post_hs_out_valid", out_valid, 0);
    check_value("post_hs_in_ready", in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_value("reset_in_ready", in_ready, 1);
    check_value("reset_out_valid", out_valid, 0);
    check_value("reset_out_data", out_data, 0);

    // Directed cases
    run_req(32'hE000_0000, 3, 2'b10, 0, 1'b0);
    run_req(32'hE000_0000, 3, 2'b00, 0, 1'b0);
    run_req(32'h0000_000F, 31, 2'b00, 0, 1'b0);
    run_req(32'h8000_0000, 31, 2'b01, 0, 1'b0);
    run_req(32'h8000_0000, 31, 2'b10, 0, 1'b0);
    run_req(32'h1234_5678, 0, 2'b10, 0, 1'b0);
    run_req(32'h0000_0001, 4, 2'b11, 0, 1'b0);
    run_req(32'h8765_4321, 13, 2'b11, 0, 1'b0);

    // Backpressure with a pending request, then that request itself
    run_req(32'h0000_0001, 5, 2'b00, 5, 1'b1);
    run_req(32'hF0F0_1234, 7, 2'b01, 0, 1'b0);

    // Reset during the second BUSY step aborts the operation
    in_data  = 32'hFFFF_0000;
    in_shamt = 5'd20;
    in_mode  = 2'b01;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_value("abort_in_ready", in_ready, 1);
    check_value("abort_out_valid", out_valid, 0);
    check_value("abort_out_data", out_data, 0);
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (out_valid) seen = 1'b1;
      end
      check_value("abort_no_result", seen, 0);
    end

    // Random requests
    for (int i = 0; i < 14; i++) begin
      run_req($urandom, int'($urandom_range(31)), 2'($urandom_range(3)),
              int'($urandom_range(2)), 1'b0);
    end

    check_value("scoreboard_empty", q_exp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
